// File: rtl/cc_cond_unit.sv
// rtl/cc_cond_unit.sv - Y86 condition-code register, jXX/cmovXX evaluator and fault freeze (option: CC_BYPASS_EN)
module cc_cond_unit #(
    parameter int         CNT_W    = 16,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_cc,
    input  logic [2:0]       alu_cc,
    input  logic             e_stall,
    input  logic             m_stat_bad,
    input  logic             w_stat_bad,
    input  logic             eval_valid,
    input  logic [3:0]       e_ifun,
    output logic [2:0]       cc,
    output logic             e_cnd,
    output logic             illegal_ifun,
    output logic             frozen,
    output logic [CNT_W-1:0] taken_cnt
);

    typedef enum logic {
        S_RUN    = 1'b0,
        S_FREEZE = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       cc_q, cc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wr_ok;
    logic [2:0]       eval_cc;
    logic             zf, sf, of, lt;

    // An in-flight exception in M or W blocks the write; W also starts the freeze.
    assign wr_ok = set_cc && !e_stall && !m_stat_bad && !w_stat_bad && (state_q == S_RUN);

`ifdef CC_BYPASS_EN
    assign eval_cc = wr_ok ? alu_cc : cc_q;
`else
    assign eval_cc = cc_q;
`endif

    assign zf = eval_cc[2];
    assign sf = eval_cc[1];
    assign of = eval_cc[0];
    assign lt = sf ^ of;

    always_comb begin
        e_cnd = 1'b0;
        case (e_ifun)
            4'd0:    e_cnd = 1'b1;
            4'd1:    e_cnd = lt | zf;
            4'd2:    e_cnd = lt;
            4'd3:    e_cnd = zf;
            4'd4:    e_cnd = ~zf;
            4'd5:    e_cnd = ~lt;
            4'd6:    e_cnd = ~lt & ~zf;
            default: e_cnd = 1'b0;
        endcase
    end

    assign illegal_ifun = eval_valid && (e_ifun > 4'd6);

    always_comb begin
        state_d = state_q;
        cc_d    = cc_q;
        cnt_d   = cnt_q;
        if (state_q == S_RUN) begin
            if (w_stat_bad) begin
                state_d = S_FREEZE;
            end
            if (wr_ok) begin
                cc_d = alu_cc;
            end
            if (eval_valid && e_cnd && !illegal_ifun && !e_stall) begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_RUN;
            cc_q    <= CC_RESET;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cc_q    <= cc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign cc        = cc_q;
    assign frozen    = (state_q == S_FREEZE);
    assign taken_cnt = cnt_q;

endmodule

// File: doc/cc_cond_unit.md
Name: cc_cond_unit

Overview:
- Consumer end of the ALU condition-code path in the pipelined execute stage.
- Latches the 3-bit {ZF,SF,OF} flags produced by the execute-stage ALU slices (and/xor/add/sub) into the architectural CC register.
- Evaluates jXX/cmovXX conditions against the stored CC.
- Enforces the Y86 rule that CC is not updated while an exception is in flight, and freezes CC permanently once a fault retires.

Parameters:
- CNT_W, 16, width of the taken-condition statistics counter.
- CC_RESET, 3'b100, CC value after reset ({ZF,SF,OF}; ZF=1, SF=0, OF=0).

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset; sampled on rising clk.
- set_cc  in  1  execute-stage instruction is OPq; request CC write.
- alu_cc  in  3  ALU flags: [2]=ZF, [1]=SF, [0]=OF.
- e_stall  in  1  execute stage held; suppresses CC write and counter update.
- m_stat_bad  in  1  memory stage holds exception status (ADR/INS/HLT).
- w_stat_bad  in  1  writeback stage holds exception status.
- eval_valid  in  1  execute stage holds a jXX/cmovXX needing evaluation.
- e_ifun  in  4  condition function code.
- cc  out  3  architectural CC register.
- e_cnd  out  1  condition result (combinational from cc).
- illegal_ifun  out  1  eval_valid with e_ifun > 6 (combinational).
- frozen  out  1  unit in FREEZE state.
- taken_cnt  out  CNT_W  count of evaluations with e_cnd=1.

Behaviour:
- Reset: when rst_n=0 at a rising edge:
  - cc <= CC_RESET, state <= RUN, frozen <= 0, taken_cnt <= 0.
  - Reset applies mid-operation and overrides all other inputs that cycle.
- FSM states: RUN, FREEZE.
  - RUN -> FREEZE on a rising edge with w_stat_bad=1.
  - FREEZE -> RUN only via reset.
  - frozen = (state==FREEZE), registered.
- CC write in RUN: cc <= alu_cc at the rising edge when set_cc=1 AND e_stall=0 AND m_stat_bad=0 AND w_stat_bad=0. Otherwise cc holds.
- In FREEZE, cc never changes.
- Write latency: one cycle. A flag produced in cycle N is visible on cc and used by e_cnd in cycle N+1.
- e_cnd decode (from registered cc, all combinational; SF^OF is XOR):
  - ifun 0 (always): 1.
  - ifun 1 (le): (SF^OF)|ZF.
  - ifun 2 (l): SF^OF.
  - ifun 3 (e): ZF.
  - ifun 4 (ne): ~ZF.
  - ifun 5 (ge): ~(SF^OF).
  - ifun 6 (g): ~(SF^OF)&~ZF.
  - ifun 7-15: e_cnd=0, and illegal_ifun=eval_valid.
  - e_cnd is driven regardless of eval_valid.
- Same-cycle set_cc and eval_valid: evaluation uses the old cc, and the write takes effect next cycle. This ordering is required because the writer is the older instruction only when it is already past execute.
- taken_cnt increments by 1 at the rising edge when eval_valid=1, e_cnd=1, illegal_ifun=0, e_stall=0 and state==RUN.
  - Wraps from 2^CNT_W-1 to 0 silently.
  - Holds in FREEZE.
- m_stat_bad alone blocks the CC write but does not freeze.
- w_stat_bad takes effect in the same edge it is sampled: the write is blocked and the FSM enters FREEZE.
- No X propagation: all registers are reset, and combinational outputs are fully decoded for all 16 ifun codes.

Optional Feature:
- Macro CC_BYPASS_EN.
- Defined: when set_cc=1 and the write is permitted this cycle, e_cnd and illegal_ifun evaluate against alu_cc instead of cc. This serves fused compare-branch experiments. taken_cnt uses the bypassed e_cnd.
- Undefined: e_cnd always uses registered cc, as specified above.

Test Plan:
- Reset check: rst_n=0 for 2 cycles, then 1 -> cc=3'b100, taken_cnt=0, frozen=0. With ifun=3, e_cnd=1; with ifun=4, e_cnd=0.
- Write and evaluate: set_cc=1, alu_cc=3'b011 for one cycle -> next cycle cc=3'b011. Then:
  - ifun 1 gives e_cnd=0.
  - ifun 2 gives e_cnd=0.
  - ifun 5 gives e_cnd=1.
  - ifun 6 gives e_cnd=1.
- Write suppression:
  - set_cc=1, alu_cc=3'b010, m_stat_bad=1 -> cc unchanged (3'b100).
  - Same stimulus with e_stall=1 -> cc unchanged.
  - Same stimulus with w_stat_bad=1 -> cc unchanged and frozen=1 next cycle.
  - Afterwards, set_cc=1, alu_cc=3'b000 -> cc stays 3'b100 until rst_n=0.
- Same-cycle ordering: cc=3'b100; in one cycle set_cc=1, alu_cc=3'b000, eval_valid=1, ifun=3 -> e_cnd=1 that cycle and cc=3'b000 next cycle.
  - With CC_BYPASS_EN defined, the same stimulus gives e_cnd=0 that cycle.
- Illegal and counter:
  - eval_valid=1, ifun=9 -> illegal_ifun=1, e_cnd=0, taken_cnt unchanged.
  - With CNT_W=4, 17 qualifying taken evaluations (ifun=0) -> taken_cnt=1 (wrap).
